fpu_addsub_stream: RTL
======================

Name: fpu_addsub_stream

Overview:
- Streaming front end for the single-precision adder/subtractor (Top_Add_Sub), i.e. the hardware issue/collect side of its operand/result interface.
- Accepts packed IEEE-754 operand pairs on a valid/ready port and splits them into S/E/M fields that drive the adder.
- Tracks in-flight operations through the adder's fixed latency, repacks {Sz,Ez,Mz} plus flags, and buffers them in a result FIFO with valid/ready backpressure.
- Sits between a command source (CPU/DMA/test sequencer) and Top_Add_Sub.

Parameters:
- LATENCY, 2, clock edges from operand-register load to valid adder outputs.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, >= LATENCY+1 for full throughput.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  32  operand X, packed IEEE-754 single.
- in_y  in  32  operand Y, packed IEEE-754 single.
- in_sub  in  1  1 = X-Y, 0 = X+Y.
- in_round  in  2  round mode (00 = nearest-even).
- Sx, Sy  out  1  operand signs to adder.
- Ex, Ey  out  8  operand exponents to adder.
- Mx, My  out  23  operand fractions to adder.
- sub  out  1  operation select to adder.
- roundMode  out  2  round mode to adder.
- Sz  in  1  result sign from adder.
- Ez  in  8  result exponent from adder.
- Mz_final  in  23  result fraction from adder.
- invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag  in  1 each  adder flags.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_z  out  32  packed result {Sz,Ez,Mz_final}.
- out_flags  out  5  {invalid,overflow,underflow,inexact,zero}.

Behaviour:
- Reset (rst=0 at a clock edge): all operand/control outputs = 0; valid pipe, FIFO pointers, count and credit counter = 0; out_valid = 0. in_ready is forced to 0 while rst=0. The reset may occur mid-operation: all in-flight and buffered results are discarded, and no stale result appears after reset.
- Accept: occurs when in_valid & in_ready at a rising edge. On accept, load {Sx,Ex,Mx} = in_x[31],[30:23],[22:0], likewise Y, plus sub and roundMode. Without an accept, these outputs hold their values.
- Credit: in_ready = rst & (inflight + fifo_count < FIFO_DEPTH). inflight = number of set bits in the valid pipe. This guarantees the FIFO never overflows.
- Valid pipe: a LATENCY-bit shift register with bit 0 = accept. When the last stage is set at an edge, push {Sz,Ez,Mz_final,flags} into the FIFO at that same edge.
- Latency: accept at edge N -> FIFO push at edge N+LATENCY -> out_valid high in the cycle after edge N+LATENCY (LATENCY+1 cycles with an empty FIFO).
- Output: out_valid = fifo_count != 0. out_z and out_flags come from the head entry, combinationally from registered storage, and stay stable while out_valid & !out_ready. Pop on out_valid & out_ready.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
- Pop when empty: impossible by construction, since out_valid = 0. A push when full is likewise prevented by credit.
- Throughput: 1 op/cycle sustained while out_ready = 1.
- Ordering: strict in-order; results return in accept order.

Decomposition:
- Package fpu_pkg:
  - constants for EXP_W=8, MAN_W=23, WORD_W=32, BIAS=127;
  - flag index constants: INVALID=4, OVERFLOW=3, UNDERFLOW=2, INEXACT=1, ZERO=0;
  - round mode encodings RNE=00, RTZ=01, RUP=10, RDN=11.
- Sub-module fpu_result_fifo: a parameterized synchronous FIFO with width 37 and depth FIFO_DEPTH, exposing push, pop, count, and head data.
- The top level holds the operand registers, valid pipe and credit logic.

Test Plan:
- Basic add: in_x=0x3F800000, in_y=0x40000000, sub=0, round=00. Expect out_z=0x40400000, out_flags=00000, out_valid asserted LATENCY+1 cycles after accept.
- Subtract to zero: in_x=0x3F800000, in_y=0x3F800000, sub=1. Expect out_z=0x00000000, out_flags=00001.
- Overflow: in_x=in_y=0x7F7FFFFF, sub=0, round=00. Expect out_z=0x7F800000, out_flags=01010.
- Backpressure: hold out_ready=0 and offer 6 ops back-to-back. Expect exactly 4 accepts, in_ready=0 afterwards, out_valid=1 with head stable. Then raise out_ready: expect 4 results in order, in_ready reasserts, and the remaining 2 ops complete.
- Streaming: out_ready=1 and 16 consecutive ops (1.0+k.0 for k=0..15). Expect 16 results on 16 consecutive cycles, in order, with no in_ready drop.
- Reset mid-flight: accept 3 ops, pulse rst=0 for one edge before the first result. Expect out_valid=0, all outputs 0, in_ready=1 after rst returns high, and no stale results afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the single-precision add/sub stream front end.
// Field widths, flag bit positions and rounding-mode encodings used by the adder.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int WORD_W = 32;
  localparam int BIAS   = 127;
  localparam int FLAG_W = 5;
  localparam int RES_W  = WORD_W + FLAG_W;

  localparam int INVALID   = 4;
  localparam int OVERFLOW  = 3;
  localparam int UNDERFLOW = 2;
  localparam int INEXACT   = 1;
  localparam int ZERO      = 0;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } round_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef struct packed {
    fp_t               z;
    logic [FLAG_W-1:0] flags;
  } result_t;

endpackage

// File: rtl/fpu_addsub_stream_if.sv
// Operand/result valid-ready stream between a command source and the add/sub front end.
// The block under control uses the slave view; the command source uses the master view.
interface fpu_addsub_stream_if;
  import fpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_x;
  logic [WORD_W-1:0] in_y;
  logic              in_sub;
  logic [1:0]        in_round;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_z;
  logic [FLAG_W-1:0] out_flags;

  modport slave (
    input  in_valid, in_x, in_y, in_sub, in_round, out_ready,
    output in_ready, out_valid, out_z, out_flags
  );

  modport master (
    output in_valid, in_x, in_y, in_sub, in_round, out_ready,
    input  in_ready, out_valid, out_z, out_flags
  );

endinterface

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO: registered storage, head entry visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is cleared on reset so no stale entry can ever reach the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count == ($clog2(DEPTH)+1)'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && count == '0));

endmodule

// File: rtl/fpu_addsub_stream.sv
// Issue/collect front end for the fixed-latency single-precision adder/subtractor.
// Splits operands into S/E/M fields, tracks in-flight ops and buffers results in order.
module fpu_addsub_stream
  import fpu_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  fpu_addsub_stream_if.slave stream,

  output logic               Sx,
  output logic               Sy,
  output logic [EXP_W-1:0]   Ex,
  output logic [EXP_W-1:0]   Ey,
  output logic [MAN_W-1:0]   Mx,
  output logic [MAN_W-1:0]   My,
  output logic               sub,
  output logic [1:0]         roundMode,

  input  logic               Sz,
  input  logic [EXP_W-1:0]   Ez,
  input  logic [MAN_W-1:0]   Mz_final,
  input  logic               invalid_flag,
  input  logic               overflow_flag,
  input  logic               underflow_flag,
  input  logic               inexact_flag,
  input  logic               zero_flag
);

  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;

  fp_t               x_p0;
  fp_t               y_p0;
  logic              sub_p0;
  round_t            rnd_p0;
  logic [LATENCY-1:0] vld_p;

  logic              accept;
  logic              push;
  logic              pop;
  logic [IF_W-1:0]   inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  credit_used;
  logic [FLAG_W-1:0] flags_in;
  result_t           push_data;
  result_t           head;

  assign accept = stream.in_valid & stream.in_ready;

  // Stage p0: operand registers feeding the adder, held until the next accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_p0   <= '0;
      y_p0   <= '0;
      sub_p0 <= 1'b0;
      rnd_p0 <= RNE;
    end else if (accept) begin
      x_p0   <= fp_t'(stream.in_x);
      y_p0   <= fp_t'(stream.in_y);
      sub_p0 <= stream.in_sub;
      rnd_p0 <= round_t'(stream.in_round);
    end
  end

  assign {Sx, Ex, Mx} = x_p0;
  assign {Sy, Ey, My} = y_p0;
  assign sub          = sub_p0;
  assign roundMode    = rnd_p0;

  // Valid pipe mirrors the adder latency; its last stage marks adder outputs as valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + IF_W'(vld_p[i]);
  end

  // Every in-flight op owns a FIFO slot, so a push can never find the FIFO full.
  assign credit_used     = SUM_W'(inflight) + SUM_W'(fifo_count);
  assign stream.in_ready = rst & (credit_used < SUM_W'(FIFO_DEPTH));

  always_comb begin
    flags_in            = '0;
    flags_in[INVALID]   = invalid_flag;
    flags_in[OVERFLOW]  = overflow_flag;
    flags_in[UNDERFLOW] = underflow_flag;
    flags_in[INEXACT]   = inexact_flag;
    flags_in[ZERO]      = zero_flag;
  end

  // Stage p(LATENCY): capture adder result into the FIFO.
  assign push_data = {Sz, Ez, Mz_final, flags_in};
  assign push      = vld_p[LATENCY-1];
  assign pop       = stream.out_valid & stream.out_ready;

  fpu_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign stream.out_valid = (fifo_count != '0);
  assign stream.out_z     = head.z;
  assign stream.out_flags = head.flags;

endmodule
